// File: rtl/rst_sequencer_if.sv
// Reset-sequencer signal bundle: PLL lock and sticky-clear in, staged resets and debug status out.
// The master side is the sequencer; the slave side is the PLL and the reset consumers.
interface rst_sequencer_if;
  logic       pll_locked;
  logic       clear_sticky;
  logic       sram_rst_n;
  logic       core_rst_n;
  logic       display_rst_n;
  logic       sys_ready;
  logic [7:0] lock_loss_count;
  logic       lock_lost_sticky;

  modport master (
    input  pll_locked,
    input  clear_sticky,
    output sram_rst_n,
    output core_rst_n,
    output display_rst_n,
    output sys_ready,
    output lock_loss_count,
    output lock_lost_sticky
  );

  modport slave (
    output pll_locked,
    output clear_sticky,
    input  sram_rst_n,
    input  core_rst_n,
    input  display_rst_n,
    input  sys_ready,
    input  lock_loss_count,
    input  lock_lost_sticky
  );
endinterface

// File: rtl/rst_sequencer.sv
// Staged reset sequencer: waits for a stable PLL lock, then releases SRAM, core and display resets
// in order; any lock loss after release began pulls everything back into reset and is counted.
module rst_sequencer #(
  parameter int unsigned STABLE_CYCLES          = 16,
  parameter int unsigned SRAM_TO_CORE_CYCLES    = 8,
  parameter int unsigned CORE_TO_DISPLAY_CYCLES = 8
) (
  input logic               clk_100,
  input logic               rst_n,
  rst_sequencer_if.master   bus
);

  localparam logic [2:0] StWaitLock = 3'd0;
  localparam logic [2:0] StStable   = 3'd1;
  localparam logic [2:0] StSram     = 3'd2;
  localparam logic [2:0] StCore     = 3'd3;
  localparam logic [2:0] StRun      = 3'd4;

  localparam logic [15:0] StableLast = 16'(STABLE_CYCLES - 1);
  localparam logic [15:0] SramLast   = 16'(SRAM_TO_CORE_CYCLES - 1);
  localparam logic [15:0] CoreLast   = 16'(CORE_TO_DISPLAY_CYCLES - 1);

  logic        sync1_q, sync2_q;
  logic [2:0]  state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        loss;
  logic [7:0]  count_q, count_d;
  logic        sticky_q, sticky_d;
  logic        sram_q, core_q, display_q, ready_q;

  always_comb begin
    state_d = state_q;
    loss    = 1'b0;
    case (state_q)
      StWaitLock: begin
        if (sync2_q) state_d = StStable;
      end
      StStable: begin
        // Dropping out of the stability window is not a counted loss.
        if (!sync2_q)                state_d = StWaitLock;
        else if (cnt_q == StableLast) state_d = StSram;
      end
      StSram: begin
        if (!sync2_q) begin
          state_d = StWaitLock;
          loss    = 1'b1;
        end else if (cnt_q == SramLast) begin
          state_d = StCore;
        end
      end
      StCore: begin
        if (!sync2_q) begin
          state_d = StWaitLock;
          loss    = 1'b1;
        end else if (cnt_q == CoreLast) begin
          state_d = StRun;
        end
      end
      StRun: begin
        if (!sync2_q) begin
          state_d = StWaitLock;
          loss    = 1'b1;
        end
      end
      default: state_d = StWaitLock;
    endcase
  end

  always_comb begin
    cnt_d = '0;
    if (state_d == state_q &&
        (state_q == StStable || state_q == StSram || state_q == StCore)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_comb begin
    count_d = count_q;
    if (loss && count_q != 8'hff) count_d = count_q + 8'd1;
    // A counted loss wins over a simultaneous clear.
    sticky_d = loss | (sticky_q & ~bus.clear_sticky);
  end

  always_ff @(posedge clk_100) begin
    if (!rst_n) begin
      sync1_q   <= 1'b0;
      sync2_q   <= 1'b0;
      state_q   <= StWaitLock;
      cnt_q     <= '0;
      count_q   <= '0;
      sticky_q  <= 1'b0;
      sram_q    <= 1'b0;
      core_q    <= 1'b0;
      display_q <= 1'b0;
      ready_q   <= 1'b0;
    end else begin
      sync1_q   <= bus.pll_locked;
      sync2_q   <= sync1_q;
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      count_q   <= count_d;
      sticky_q  <= sticky_d;
      // Decode from the next state so outputs move on the same edge as the state.
      sram_q    <= (state_d == StSram) || (state_d == StCore) || (state_d == StRun);
      core_q    <= (state_d == StCore) || (state_d == StRun);
      display_q <= (state_d == StRun);
      ready_q   <= (state_d == StRun);
    end
  end

  assign bus.sram_rst_n       = sram_q;
  assign bus.core_rst_n       = core_q;
  assign bus.display_rst_n    = display_q;
  assign bus.sys_ready        = ready_q;
  assign bus.lock_loss_count  = count_q;
  assign bus.lock_lost_sticky = sticky_q;

endmodule

// File: doc/rst_sequencer.md
Name: rst_sequencer

Overview:
- Consumes the `pll_locked` indicator from the clock-generation block and produces staged, synchronous active-low resets for the SRAM controller, GPU core and display pipeline.
- Runs entirely in the 100 MHz domain.
- Synchronizes the asynchronous lock signal and requires a stable-lock window before releasing anything.
- Releases resets in order SRAM → core → display, and re-asserts all of them on lock loss, with loss counting for debug.

Parameters:
- STABLE_CYCLES, 16: consecutive synchronized-lock cycles required before SRAM reset release; legal 1..65535.
- SRAM_TO_CORE_CYCLES, 8: cycles between SRAM release and core release; legal 1..65535.
- CORE_TO_DISPLAY_CYCLES, 8: cycles between core release and display release; legal 1..65535.

Ports:
- clk_100, input, 1: 100 MHz clock; only clock of the block.
- rst_n, input, 1: synchronous active-low reset, sampled on rising clk_100.
- pll_locked, input, 1: PLL lock indicator; asynchronous to clk_100.
- clear_sticky, input, 1: single-cycle pulse that clears lock_lost_sticky.
- sram_rst_n, output, 1: SRAM controller reset, active-low, registered.
- core_rst_n, output, 1: GPU core reset, active-low, registered.
- display_rst_n, output, 1: display/TMDS-side reset, active-low, registered.
- sys_ready, output, 1: high only in RUN.
- lock_loss_count, output, 8: saturating count of lock losses after release began.
- lock_lost_sticky, output, 1: set on any counted lock loss.

Behaviour:
- **Interface decision:** one clock (clk_100); reset rst_n is synchronous and active-low.
- **Reset (rst_n=0 at an edge):**
  - All outputs go 0 after that edge.
  - State = WAIT_LOCK, counter = 0, both sync flops = 0.
  - This applies at any time, including mid-sequence.
- **Synchronizer:** 2-flop; lock_s = second flop. No combinational path from pll_locked to outputs.
- **Counter:** 16-bit, cleared on every state change.
- **Outputs:** all registered, Moore, decoded from the next state so they change on the same edge as the state.
- **WAIT_LOCK:**
  - All resets 0, sys_ready 0.
  - lock_s=1 → STABLE.
- **STABLE:**
  - All resets 0.
  - lock_s=0 → WAIT_LOCK; not counted as a loss.
  - Else if cnt==STABLE_CYCLES-1 → SRAM; otherwise cnt+1.
- **SRAM:**
  - sram_rst_n=1, others 0.
  - cnt==SRAM_TO_CORE_CYCLES-1 → CORE; otherwise cnt+1.
- **CORE:**
  - sram_rst_n=1, core_rst_n=1, display_rst_n=0.
  - cnt==CORE_TO_DISPLAY_CYCLES-1 → RUN; otherwise cnt+1.
- **RUN:** all resets 1, sys_ready=1; holds indefinitely while lock_s=1.
- **Lock loss in SRAM/CORE/RUN (lock_s=0 at an edge):**
  - Takes priority over the counter transition.
  - Next state WAIT_LOCK; all resets 0 and sys_ready 0 after that edge.
  - lock_loss_count +1, saturating at 255.
  - lock_lost_sticky set.
- **Sticky clear:** clear_sticky=1 clears lock_lost_sticky unless a counted loss occurs on the same edge; set wins. lock_loss_count is cleared only by rst_n.
- **Latency, release:** pll_locked first sampled high at edge 1 → sync2 high after edge 2 → STABLE after edge 3. With defaults:
  - sram_rst_n rises after edge 3+STABLE_CYCLES = 19.
  - core_rst_n rises after edge 27.
  - display_rst_n and sys_ready rise after edge 35.
- **Latency, loss:** pll_locked first sampled low at edge e → outputs low after edge e+2.
- **Release ordering:** resets are never released out of order. display_rst_n=1 implies core_rst_n=1, which implies sram_rst_n=1.
- **Re-lock:** after any return to WAIT_LOCK, the full sequence reruns from STABLE with fresh counts.

Test Plan:
- **Normal release:** defaults, rst_n released, pll_locked=1 held from edge 1 → sram_rst_n↑ after edge 19, core_rst_n↑ after edge 27, display_rst_n and sys_ready↑ after edge 35; lock_loss_count=0.
- **Glitch during STABLE:** pll_locked high 10 cycles, low 3, high → no reset released early; sram_rst_n↑ exactly 3+16 edges after the re-rise is sampled; lock_loss_count=0, sticky=0.
- **Loss in RUN:** drop pll_locked at edge e → all resets and sys_ready 0 after edge e+2; lock_loss_count=1, sticky=1; restore lock → full staged release again.
- **Loss in CORE plus sticky clear:** loss in CORE → count=1; then clear_sticky pulse → sticky=0, count stays 1; a later loss coinciding with clear_sticky → sticky=1, count=2.
- **Saturation:** 260 loss events after reaching SRAM each time → lock_loss_count=255, no wrap.
- **Reset mid-sequence:** rst_n=0 while in CORE → all outputs and count 0 after that edge; after rst_n=1 with lock held → sram_rst_n↑ 19 edges later.
